// File: rtl/cplx_pkg.sv
// -----------------------------------------------------------------------------
// cplx_pkg
// Shared definitions for the complex ALU that sits downstream of the complex
// register bank.
// Contents:
//   W              : width of one real or imaginary field
//   OP_*           : 3-bit opcodes accepted on the ALU 'op' port
//   ST_*           : FSM state encoding for cplx_alu
//   RE(x) / IM(x)  : field extraction from a packed {re, im} word
// Configuration macro used by the datapath: CPLX_ALU_SAT_EN
// -----------------------------------------------------------------------------
package cplx_pkg;

    localparam int W = 32;

    // Opcodes
    localparam logic [2:0] OP_ADD    = 3'b000;
    localparam logic [2:0] OP_SUB    = 3'b001;
    localparam logic [2:0] OP_MUL    = 3'b010;
    localparam logic [2:0] OP_MAC    = 3'b011;
    localparam logic [2:0] OP_CONJ   = 3'b100;
    localparam logic [2:0] OP_NEG    = 3'b101;
    localparam logic [2:0] OP_CLRACC = 3'b110;
    localparam logic [2:0] OP_RSVD   = 3'b111;

    // FSM state encoding
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_EXEC = 3'd1;
    localparam logic [2:0] ST_M0   = 3'd2;
    localparam logic [2:0] ST_M1   = 3'd3;
    localparam logic [2:0] ST_M2   = 3'd4;
    localparam logic [2:0] ST_M3   = 3'd5;
    localparam logic [2:0] ST_COMB = 3'd6;

    // Real part lives in the upper half of a packed complex word
    function automatic logic [W-1:0] RE(input logic [2*W-1:0] x);
        return x[2*W-1:W];
    endfunction

    // Imaginary part lives in the lower half of a packed complex word
    function automatic logic [W-1:0] IM(input logic [2*W-1:0] x);
        return x[W-1:0];
    endfunction

endpackage

// File: rtl/cplx_sat.sv
// -----------------------------------------------------------------------------
// cplx_sat
// Combinational reduction of a wider two's-complement value to OW bits.
//   CPLX_ALU_SAT_EN defined   : clamp to [-2^(OW-1), 2^(OW-1)-1]
//   CPLX_ALU_SAT_EN undefined : keep the low OW bits (wrap)
// Ports:
//   val_i  in  IW  signed input value
//   val_o  out OW  clamped / truncated result
// -----------------------------------------------------------------------------
module cplx_sat #(
    parameter int IW = 33,
    parameter int OW = 32
) (
    input  logic signed [IW-1:0] val_i,
    output logic        [OW-1:0] val_o
);

`ifdef CPLX_ALU_SAT_EN
    // Bounds expressed at the input width so the comparison stays signed
    localparam logic signed [IW-1:0] MAX_V = $signed({{(IW-OW+1){1'b0}}, {(OW-1){1'b1}}});
    localparam logic signed [IW-1:0] MIN_V = $signed({{(IW-OW+1){1'b1}}, {(OW-1){1'b0}}});

    // Clamp out-of-range values to the nearest representable bound
    always_comb begin
        if (val_i > MAX_V) begin
            val_o = {1'b0, {(OW-1){1'b1}}};
        end else if (val_i < MIN_V) begin
            val_o = {1'b1, {(OW-1){1'b0}}};
        end else begin
            val_o = val_i[OW-1:0];
        end
    end
`else
    // Upper bits are intentionally discarded in the wrapping build
    logic unused_hi_s;
    assign unused_hi_s = ^val_i[IW-1:OW];

    // Plain truncation: arithmetic wraps modulo 2^OW
    always_comb begin
        val_o = val_i[OW-1:0];
    end
`endif

endmodule

// File: rtl/cplx_alu.sv
// -----------------------------------------------------------------------------
// cplx_alu
// Sequential complex ALU: add, sub, mul, mac, conj, neg, clear-accumulator.
// Operands are packed {re[2W-1:W], im[W-1:0]}. Multiplication reuses one
// W x W signed multiplier over four cycles (M0..M3) then combines in COMB.
// Optional saturation: define CPLX_ALU_SAT_EN (default build wraps).
// Ports:
//   clock   in   1    posedge clock
//   reset   in   1    synchronous, active-high
//   start   in   1    request, sampled only while idle
//   op      in   3    opcode, captured with start
//   opA     in   2W   operand A (bank outA)
//   opB     in   2W   operand B (bank outB)
//   busy    out  1    high while the FSM is not idle
//   done    out  1    one-cycle pulse, result valid
//   result  out  2W   registered result, held until the next done
//   wen     out  1    copy of done, drives bank regwen
// -----------------------------------------------------------------------------
module cplx_alu #(
    parameter int W = 32
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           start,
    input  logic [2:0]     op,
    input  logic [2*W-1:0] opA,
    input  logic [2*W-1:0] opB,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] result,
    output logic           wen
);

    import cplx_pkg::*;

    // State and captured operands
    logic [2:0]     state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [2*W-1:0] a_q, a_d;
    logic [2*W-1:0] b_q, b_d;
    logic [W-1:0]   p0_q, p0_d;
    logic [W-1:0]   p1_q, p1_d;
    logic [W-1:0]   p2_q, p2_d;
    logic [W-1:0]   p3_q, p3_d;
    logic [2*W-1:0] acc_q, acc_d;
    logic [2*W-1:0] result_q, result_d;
    logic           done_q, done_d;
    logic           busy_q, busy_d;

    // Sign-extended operand fields (one guard bit keeps sums exact)
    logic signed [W:0] ar_x_s, ai_x_s, br_x_s, bi_x_s;
    assign ar_x_s = {a_q[2*W-1], a_q[2*W-1:W]};
    assign ai_x_s = {a_q[W-1],   a_q[W-1:0]};
    assign br_x_s = {b_q[2*W-1], b_q[2*W-1:W]};
    assign bi_x_s = {b_q[W-1],   b_q[W-1:0]};

    // ---------------- single-cycle ops ----------------
    logic signed [W:0] simple_re_w_s, simple_im_w_s;
    logic [W-1:0]      simple_re_s, simple_im_s;

    // Exact (W+1)-bit result of the non-multiply operations
    always_comb begin
        simple_re_w_s = ar_x_s;
        simple_im_w_s = ai_x_s;
        case (op_q)
            OP_ADD: begin
                simple_re_w_s = ar_x_s + br_x_s;
                simple_im_w_s = ai_x_s + bi_x_s;
            end
            OP_SUB: begin
                simple_re_w_s = ar_x_s - br_x_s;
                simple_im_w_s = ai_x_s - bi_x_s;
            end
            OP_CONJ: begin
                simple_re_w_s = ar_x_s;
                simple_im_w_s = -ai_x_s;
            end
            OP_NEG: begin
                simple_re_w_s = -ar_x_s;
                simple_im_w_s = -ai_x_s;
            end
            default: begin
                simple_re_w_s = ar_x_s;
                simple_im_w_s = ai_x_s;
            end
        endcase
    end

    cplx_sat #(.IW(W+1), .OW(W)) u_sat_simple_re (.val_i(simple_re_w_s), .val_o(simple_re_s));
    cplx_sat #(.IW(W+1), .OW(W)) u_sat_simple_im (.val_i(simple_im_w_s), .val_o(simple_im_s));

    // ---------------- shared multiplier ----------------
    logic [W-1:0]   mul_a_s, mul_b_s;
    logic [2*W-1:0] mul_full_s;
    logic [W-1:0]   mul_sat_s;

    // Steer the operand pair for the partial product owned by each M state
    always_comb begin
        mul_a_s = a_q[2*W-1:W];
        mul_b_s = b_q[2*W-1:W];
        case (state_q)
            ST_M0: begin mul_a_s = a_q[2*W-1:W]; mul_b_s = b_q[2*W-1:W]; end
            ST_M1: begin mul_a_s = a_q[W-1:0];   mul_b_s = b_q[W-1:0];   end
            ST_M2: begin mul_a_s = a_q[2*W-1:W]; mul_b_s = b_q[W-1:0];   end
            ST_M3: begin mul_a_s = a_q[W-1:0];   mul_b_s = b_q[2*W-1:W]; end
            default: begin mul_a_s = a_q[2*W-1:W]; mul_b_s = b_q[2*W-1:W]; end
        endcase
    end

    // Sign-extend to 2W so the low 2W bits of the product are the signed product
    assign mul_full_s = {{W{mul_a_s[W-1]}}, mul_a_s} * {{W{mul_b_s[W-1]}}, mul_b_s};

    cplx_sat #(.IW(2*W), .OW(W)) u_sat_prod (.val_i(mul_full_s), .val_o(mul_sat_s));

    // ---------------- combine and accumulate ----------------
    logic signed [W:0] comb_re_w_s, comb_im_w_s;
    logic [W-1:0]      comb_re_s, comb_im_s;
    logic signed [W:0] mac_re_w_s, mac_im_w_s;
    logic [W-1:0]      mac_re_s, mac_im_s;
    logic signed [W:0] p0_x_s, p1_x_s, p2_x_s, p3_x_s;

    assign p0_x_s = {p0_q[W-1], p0_q};
    assign p1_x_s = {p1_q[W-1], p1_q};
    assign p2_x_s = {p2_q[W-1], p2_q};
    assign p3_x_s = {p3_q[W-1], p3_q};

    assign comb_re_w_s = p0_x_s - p1_x_s;
    assign comb_im_w_s = p2_x_s + p3_x_s;

    cplx_sat #(.IW(W+1), .OW(W)) u_sat_comb_re (.val_i(comb_re_w_s), .val_o(comb_re_s));
    cplx_sat #(.IW(W+1), .OW(W)) u_sat_comb_im (.val_i(comb_im_w_s), .val_o(comb_im_s));

    assign mac_re_w_s = $signed({acc_q[2*W-1], acc_q[2*W-1:W]}) + $signed({comb_re_s[W-1], comb_re_s});
    assign mac_im_w_s = $signed({acc_q[W-1], acc_q[W-1:0]})     + $signed({comb_im_s[W-1], comb_im_s});

    cplx_sat #(.IW(W+1), .OW(W)) u_sat_mac_re (.val_i(mac_re_w_s), .val_o(mac_re_s));
    cplx_sat #(.IW(W+1), .OW(W)) u_sat_mac_im (.val_i(mac_im_w_s), .val_o(mac_im_s));

    // ---------------- control ----------------

    // FSM next state and next values of every datapath register
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        p0_d     = p0_q;
        p1_d     = p1_q;
        p2_d     = p2_q;
        p3_d     = p3_q;
        acc_d    = acc_q;
        result_d = result_q;
        done_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d = op;
                    a_d  = opA;
                    b_d  = opB;
                    if ((op == OP_MUL) || (op == OP_MAC)) begin
                        state_d = ST_M0;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                case (op_q)
                    OP_ADD, OP_SUB, OP_CONJ, OP_NEG: begin
                        result_d = {simple_re_s, simple_im_s};
                    end
                    OP_CLRACC: begin
                        acc_d    = {(2*W){1'b0}};
                        result_d = {(2*W){1'b0}};
                    end
                    default: begin
                        // reserved opcode: handshake only, result held
                        result_d = result_q;
                    end
                endcase
            end
            ST_M0: begin
                p0_d    = mul_sat_s;
                state_d = ST_M1;
            end
            ST_M1: begin
                p1_d    = mul_sat_s;
                state_d = ST_M2;
            end
            ST_M2: begin
                p2_d    = mul_sat_s;
                state_d = ST_M3;
            end
            ST_M3: begin
                p3_d    = mul_sat_s;
                state_d = ST_COMB;
            end
            ST_COMB: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
                if (op_q == OP_MAC) begin
                    acc_d    = {mac_re_s, mac_im_s};
                    result_d = {mac_re_s, mac_im_s};
                end else begin
                    result_d = {comb_re_s, comb_im_s};
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    // State and datapath registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            a_q      <= {(2*W){1'b0}};
            b_q      <= {(2*W){1'b0}};
            p0_q     <= {W{1'b0}};
            p1_q     <= {W{1'b0}};
            p2_q     <= {W{1'b0}};
            p3_q     <= {W{1'b0}};
            acc_q    <= {(2*W){1'b0}};
            result_q <= {(2*W){1'b0}};
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            p0_q     <= p0_d;
            p1_q     <= p1_d;
            p2_q     <= p2_d;
            p3_q     <= p3_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign wen    = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_cplx_alu.sv
// -----------------------------------------------------------------------------
// tb_cplx_alu
// Directed self-checking bench for cplx_alu. Expected values are hand-derived
// complex arithmetic results; saturation-dependent expectations follow
// CPLX_ALU_SAT_EN.
// -----------------------------------------------------------------------------
module tb_cplx_alu;

    logic        clock;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [63:0] opA;
    logic [63:0] opB;
    logic        busy;
    logic        done;
    logic [63:0] result;
    logic        wen;

    int n_cmp;
    int n_fail;
    logic done_at_start;

    cplx_alu #(.W(32)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .opA    (opA),
        .opB    (opB),
        .busy   (busy),
        .done   (done),
        .result (result),
        .wen    (wen)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Issue one request and wait (bounded) for done; lat counts edges after edge 0
    task automatic run_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                          output int lat, output int bcnt);
        @(negedge clock);
        done_at_start = done;
        start = 1'b1; op = o; opA = a; opB = b;
        @(posedge clock); #1;
        start = 1'b0;
        lat = 0; bcnt = 0;
        while (done !== 1'b1 && lat < 20) begin
            if (busy === 1'b1) bcnt++;
            @(posedge clock); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; op = 3'b000; opA = 64'h0; opB = 64'h0;
        repeat (2) @(posedge clock);
        #1;
        n_cmp++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_cmp++; if (done !== 1'b0)   begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_cmp++; if (wen !== 1'b0)    begin n_fail++; $display("FAIL reset_wen: got %b expected 0", wen); end
        n_cmp++; if (result !== 64'h0) begin n_fail++; $display("FAIL reset_result: got %h expected 0", result); end
        reset = 1'b0;
    endtask

    task automatic test_add();
        int lat, bc;
        run_op(3'b000, 64'h00000003_00000004, 64'h00000001_FFFFFFFE, lat, bc);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d expected 1", lat); end
        n_cmp++; if (bc !== 1)  begin n_fail++; $display("FAIL add_busy_cycles: got %0d expected 1", bc); end
        n_cmp++; if (result !== 64'h00000004_00000002) begin n_fail++; $display("FAIL add_result: got %h expected 0000000400000002", result); end
        n_cmp++; if (wen !== done) begin n_fail++; $display("FAIL add_wen: got %b expected %b", wen, done); end
        @(posedge clock); #1;
        n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL add_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_simple_ops();
        int lat, bc;
        logic [63:0] exp_neg;
`ifdef CPLX_ALU_SAT_EN
        exp_neg = 64'h7FFFFFFF_FFFFFFFF;
`else
        exp_neg = 64'h80000000_FFFFFFFF;
`endif
        run_op(3'b001, 64'h00000005_00000001, 64'h00000007_00000003, lat, bc);
        n_cmp++; if (result !== 64'hFFFFFFFE_FFFFFFFE) begin n_fail++; $display("FAIL sub_result: got %h expected FFFFFFFEFFFFFFFE", result); end
        run_op(3'b100, 64'h00000009_00000005, 64'h0, lat, bc);
        n_cmp++; if (result !== 64'h00000009_FFFFFFFB) begin n_fail++; $display("FAIL conj_result: got %h expected 00000009FFFFFFFB", result); end
        run_op(3'b101, 64'h80000000_00000001, 64'h0, lat, bc);
        n_cmp++; if (result !== exp_neg) begin n_fail++; $display("FAIL neg_result: got %h expected %h", result, exp_neg); end
        run_op(3'b111, 64'h12345678_9ABCDEF0, 64'h11111111_22222222, lat, bc);
        n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL nop_latency: got %0d expected 1", lat); end
        n_cmp++; if (result !== exp_neg) begin n_fail++; $display("FAIL nop_result_held: got %h expected %h", result, exp_neg); end
    endtask

    task automatic test_mul();
        int lat, bc;
        run_op(3'b010, 64'h00000001_00000002, 64'h00000003_00000004, lat, bc);
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL mul_latency: got %0d expected 5", lat); end
        n_cmp++; if (bc !== 5)  begin n_fail++; $display("FAIL mul_busy_cycles: got %0d expected 5", bc); end
        n_cmp++; if (result !== 64'hFFFFFFFB_0000000A) begin n_fail++; $display("FAIL mul_result: got %h expected FFFFFFFB0000000A", result); end
        n_cmp++; if (wen !== 1'b1) begin n_fail++; $display("FAIL mul_wen: got %b expected 1", wen); end
    endtask

    task automatic test_back_to_back_mac();
        int lat, bc;
        run_op(3'b110, 64'h0, 64'h0, lat, bc);
        n_cmp++; if (result !== 64'h0) begin n_fail++; $display("FAIL clracc_result: got %h expected 0", result); end
        run_op(3'b011, 64'h00000001_00000001, 64'h00000001_00000001, lat, bc);
        n_cmp++; if (result !== 64'h00000000_00000002) begin n_fail++; $display("FAIL mac1_result: got %h expected 0000000000000002", result); end
        // next request is raised while done is still high
        run_op(3'b011, 64'h00000001_00000001, 64'h00000001_00000001, lat, bc);
        n_cmp++; if (done_at_start !== 1'b1) begin n_fail++; $display("FAIL b2b_start_in_done: got %b expected 1", done_at_start); end
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL mac2_latency: got %0d expected 5", lat); end
        n_cmp++; if (result !== 64'h00000000_00000004) begin n_fail++; $display("FAIL mac2_result: got %h expected 0000000000000004", result); end
    endtask

    task automatic test_overflow();
        int lat, bc;
        logic [63:0] exp_ovf;
`ifdef CPLX_ALU_SAT_EN
        exp_ovf = 64'h7FFFFFFF_00000000;
`else
        exp_ovf = 64'h80000000_00000000;
`endif
        run_op(3'b000, 64'h7FFFFFFF_00000000, 64'h00000001_00000000, lat, bc);
        n_cmp++; if (result !== exp_ovf) begin n_fail++; $display("FAIL add_overflow: got %h expected %h", result, exp_ovf); end
    endtask

    task automatic test_busy_reject();
        int cyc, ndone, lat;
        @(negedge clock);
        start = 1'b1; op = 3'b010; opA = 64'h00000002_00000003; opB = 64'h00000004_00000005;
        @(posedge clock); #1;            // edge 0
        start = 1'b0;
        @(negedge clock);                // cycle 1 -> 2
        @(posedge clock); #1;            // edge 1
        start = 1'b1; op = 3'b000; opA = 64'h11111111_11111111;
        @(posedge clock); #1;            // edge 2
        start = 1'b0;
        ndone = 0; lat = 0;
        for (cyc = 2; cyc < 12; cyc++) begin
            if (done === 1'b1) begin
                ndone++;
                if (lat == 0) lat = cyc;
                n_cmp++; if (result !== 64'hFFFFFFF9_00000016) begin n_fail++; $display("FAIL reject_result: got %h expected FFFFFFF900000016", result); end
            end
            @(posedge clock); #1;
        end
        n_cmp++; if (ndone !== 1) begin n_fail++; $display("FAIL reject_done_count: got %0d expected 1", ndone); end
        n_cmp++; if (lat !== 5) begin n_fail++; $display("FAIL reject_latency: got %0d expected 5", lat); end
    endtask

    task automatic test_reset_mid_mac();
        int ndone, lat, bc;
        @(negedge clock);
        start = 1'b1; op = 3'b011; opA = 64'h00000001_00000001; opB = 64'h00000001_00000001;
        @(posedge clock); #1;            // edge 0
        start = 1'b0;
        @(posedge clock);                // edge 1
        @(posedge clock);                // edge 2
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock); #1;            // edge 3 applies reset
        reset = 1'b0;
        n_cmp++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL midrst_busy: got %b expected 0", busy); end
        n_cmp++; if (result !== 64'h0) begin n_fail++; $display("FAIL midrst_result: got %h expected 0", result); end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            if (done === 1'b1) ndone++;
            @(posedge clock); #1;
        end
        n_cmp++; if (ndone !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
        run_op(3'b011, 64'h00000002_00000000, 64'h00000003_00000000, lat, bc);
        n_cmp++; if (result !== 64'h00000006_00000000) begin n_fail++; $display("FAIL midrst_mac_acc: got %h expected 0000000600000000", result); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        done_at_start = 1'b0;
        test_reset();
        test_add();
        test_simple_ops();
        test_mul();
        test_back_to_back_mac();
        test_overflow();
        test_busy_reject();
        test_reset_mid_mac();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
